unspiral: RTL and testbench

//  Inverse of the spiral matrix reorderer: accepts a row x col matrix whose elements arrive in

---
 rtl/unspiral.sv | 162 ++++++++++++++++
 tb/tb_unspiral.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/unspiral.sv
// Spiral-order to raster-order matrix decoder: fill one matrix fully, then drain it fully.
// Optional data_out_last output is enabled by defining UNSPIRAL_LAST_EN.
module unspiral #(
  parameter int DATA_WIDTH = 8,
  parameter int R_WIDTH    = 3,
  parameter int C_WIDTH    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [R_WIDTH-1:0]    row,
  input  logic [C_WIDTH-1:0]    col,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic                  data_in_rdy,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_rdy,
`ifdef UNSPIRAL_LAST_EN
  output logic                  data_out_last,
`endif
  output logic [1:0]            state_dbg
);
  // Handshake: a beat moves on a rising edge where valid && rdy; the producer holds
  // data/valid stable until that edge, and rdy never depends combinationally on valid.
  localparam int MAX_R = 1 << R_WIDTH;
  localparam int MAX_C = 1 << C_WIDTH;
  localparam int TW    = R_WIDTH + C_WIDTH;

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, DRAIN = 2'd2} state_t;
  typedef enum logic [1:0] {L2R = 2'd0, U2D = 2'd1, R2L = 2'd2, D2U = 2'd3} dir_t;

  state_t state, state_next;
  dir_t   dir, cur_dir, nxt_dir;

  logic [R_WIDTH-1:0] wr_r, top, bot, rd_r, row_reg;
  logic [R_WIDTH-1:0] cur_r, cur_top, cur_bot, nxt_r, nxt_top, nxt_bot;
  logic [C_WIDTH-1:0] wr_c, lft, rgt, rd_c, col_reg;
  logic [C_WIDTH-1:0] cur_c, cur_lft, cur_rgt, nxt_c, nxt_lft, nxt_rgt;
  logic [TW-1:0]      cnt, total, cur_cnt, cur_total, nxt_cnt;
  logic               in_acc, out_acc, rd_last_c, rd_last_r;

  logic [DATA_WIDTH-1:0] mem [MAX_R][MAX_C];

  always_comb begin
    in_acc    = data_in_valid && data_in_rdy;
    out_acc   = data_out_valid && data_out_rdy;
    rd_last_c = (rd_c == col_reg - C_WIDTH'(1));
    rd_last_r = (rd_r == row_reg - R_WIDTH'(1));

    // In IDLE the walk starts from freshly derived bounds so the first beat steps correctly.
    if (state == IDLE) begin
      cur_r     = '0;
      cur_c     = '0;
      cur_top   = '0;
      cur_bot   = row - R_WIDTH'(1);
      cur_lft   = '0;
      cur_rgt   = col - C_WIDTH'(1);
      cur_dir   = L2R;
      cur_cnt   = '0;
      cur_total = TW'(row) * TW'(col);
    end else begin
      cur_r     = wr_r;
      cur_c     = wr_c;
      cur_top   = top;
      cur_bot   = bot;
      cur_lft   = lft;
      cur_rgt   = rgt;
      cur_dir   = dir;
      cur_cnt   = cnt;
      cur_total = total;
    end

    nxt_r   = cur_r;
    nxt_c   = cur_c;
    nxt_top = cur_top;
    nxt_bot = cur_bot;
    nxt_lft = cur_lft;
    nxt_rgt = cur_rgt;
    nxt_dir = cur_dir;
    case (cur_dir)
      L2R: if (cur_c == cur_rgt) begin
             nxt_top = cur_top + R_WIDTH'(1); nxt_dir = U2D; nxt_r = cur_r + R_WIDTH'(1);
           end else nxt_c = cur_c + C_WIDTH'(1);
      U2D: if (cur_r == cur_bot) begin
             nxt_rgt = cur_rgt - C_WIDTH'(1); nxt_dir = R2L; nxt_c = cur_c - C_WIDTH'(1);
           end else nxt_r = cur_r + R_WIDTH'(1);
      R2L: if (cur_c == cur_lft) begin
             nxt_bot = cur_bot - R_WIDTH'(1); nxt_dir = D2U; nxt_r = cur_r - R_WIDTH'(1);
           end else nxt_c = cur_c - C_WIDTH'(1);
      default: if (cur_r == cur_top) begin
             nxt_lft = cur_lft + C_WIDTH'(1); nxt_dir = L2R; nxt_c = cur_c + C_WIDTH'(1);
           end else nxt_r = cur_r - R_WIDTH'(1);
    endcase
    nxt_cnt = cur_cnt + TW'(1);

    state_next = state;
    case (state)
      IDLE, FILL: if (in_acc) state_next = (nxt_cnt == cur_total) ? DRAIN : FILL;
      DRAIN:      if (out_acc && rd_last_c && rd_last_r) state_next = IDLE;
      default:    state_next = IDLE;
    endcase

    data_out_valid = (state == DRAIN);
    data_out       = data_out_valid ? mem[rd_r][rd_c] : '0;
`ifdef UNSPIRAL_LAST_EN
    data_out_last  = data_out_valid && rd_last_c && rd_last_r;
`endif
  end

  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      data_in_rdy <= 1'b0;
      wr_r        <= '0;
      wr_c        <= '0;
      top         <= '0;
      bot         <= '0;
      lft         <= '0;
      rgt         <= '0;
      dir         <= L2R;
      cnt         <= '0;
      total       <= '0;
      row_reg     <= '0;
      col_reg     <= '0;
      rd_r        <= '0;
      rd_c        <= '0;
    end else begin
      state       <= state_next;
      data_in_rdy <= (state_next != DRAIN);
      if (in_acc) begin
        wr_r <= nxt_r;
        wr_c <= nxt_c;
        top  <= nxt_top;
        bot  <= nxt_bot;
        lft  <= nxt_lft;
        rgt  <= nxt_rgt;
        dir  <= nxt_dir;
        cnt  <= nxt_cnt;
        if (state == IDLE) begin
          row_reg <= row;
          col_reg <= col;
          total   <= cur_total;
        end
      end
      // Read pointers return to [0][0] on the final accept, ready for the next matrix.
      if (out_acc) begin
        if (rd_last_c) begin
          rd_c <= '0;
          rd_r <= rd_last_r ? '0 : rd_r + R_WIDTH'(1);
        end else begin
          rd_c <= rd_c + C_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_acc) mem[cur_r][cur_c] <= data_in;
  end
endmodule

// File: tb/tb_unspiral.sv
// Bench for unspiral: directed spiral-order matrices, queue scoreboard with a negedge monitor.
module tb_unspiral;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] row = '0;
  logic [2:0] col = '0;
  logic [7:0] data_in = '0;
  logic       data_in_valid = 1'b0;
  logic       data_out_rdy = 1'b1;
  wire        data_in_rdy;
  wire  [7:0] data_out;
  wire        data_out_valid;
  wire  [1:0] state_dbg;
`ifdef UNSPIRAL_LAST_EN
  wire        data_out_last;
`endif

  unspiral dut (
    .clk(clk), .rst(rst), .row(row), .col(col),
    .data_in(data_in), .data_in_valid(data_in_valid), .data_in_rdy(data_in_rdy),
    .data_out(data_out), .data_out_valid(data_out_valid), .data_out_rdy(data_out_rdy),
`ifdef UNSPIRAL_LAST_EN
    .data_out_last(data_out_last),
`endif
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [8:0] exp_q[$];   // {last, data}
  logic [7:0] in_q[$];
  bit rdy_toggle = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // downstream ready: steady 1 or toggling each cycle, changed just after the edge
  always @(posedge clk) begin
    #1;
    if (rdy_toggle) data_out_rdy = ~data_out_rdy;
    else            data_out_rdy = 1'b1;
  end

  // driver tasks
  task automatic push_exp(input int v, input bit last);
    exp_q.push_back({last, 8'(v)});
  endtask

  task automatic push_seq(input int first, input int n);
    for (int k = 0; k < n; k++) push_exp(first + k, k == n - 1);
  endtask

  task automatic drive_matrix(input int r, input int c, input int n);
    int t;
    for (int k = 0; k < n; k++) begin
      data_in       = in_q.pop_front();
      data_in_valid = 1'b1;
      if (k == 0) begin row = 3'(r); col = 3'(c); end
      else begin row = 3'(~r); col = 3'(~c); end
      t = 0;
      while (!data_in_rdy && t < 200) begin @(negedge clk); t++; end
      if (t >= 200) begin
        check("in_rdy_timeout", 32'(t), 32'd0);
        data_in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    data_in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 1000) begin @(negedge clk); t++; end
    if (t >= 1000) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  // reference: walk layers of an r x c matrix, numbering positions in spiral order
  task automatic model_matrix(input int r, input int c, input int base);
    int idx[8][8];
    int t, b, l, rt, k;
    t = 0; b = r - 1; l = 0; rt = c - 1; k = 0;
    while (t <= b && l <= rt) begin
      for (int j = l; j <= rt; j++) begin idx[t][j] = k; k++; end
      for (int i = t + 1; i <= b; i++) begin idx[i][rt] = k; k++; end
      if (t < b) for (int j = rt - 1; j >= l; j--) begin idx[b][j] = k; k++; end
      if (l < rt) for (int i = b - 1; i > t; i--) begin idx[i][l] = k; k++; end
      t++; b--; l++; rt--;
    end
    for (int n = 0; n < r * c; n++) in_q.push_back(8'(base + n));
    for (int i = 0; i < r; i++)
      for (int j = 0; j < c; j++)
        push_exp(base + idx[i][j], (i == r - 1) && (j == c - 1));
  endtask

  // scoreboard monitor
  logic [8:0] mon_e;
  logic [7:0] held;
  bit stalled = 1'b0;
  always @(negedge clk) begin
    if (rst) stalled = 1'b0;
    else if (data_out_valid) begin
      if (stalled) check("stall_hold", 32'(data_out), 32'(held));
      if (data_out_rdy) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_out: got %0h expected none", data_out);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_data", 32'(data_out), 32'(mon_e[7:0]));
`ifdef UNSPIRAL_LAST_EN
          check("out_last", 32'(data_out_last), 32'(mon_e[8]));
`endif
        end
      end
      stalled = !data_out_rdy;
      held    = data_out;
    end else stalled = 1'b0;
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_in_rdy", 32'(data_in_rdy), 32'd0);
    check("rst_out_valid", 32'(data_out_valid), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    rst = 1'b0;
    #1 check("rdy_before_edge", 32'(data_in_rdy), 32'd0);
    @(negedge clk);
    check("rdy_after_edge", 32'(data_in_rdy), 32'd1);

    // 3x3
    in_q = '{8'd1, 8'd2, 8'd3, 8'd6, 8'd9, 8'd8, 8'd7, 8'd4, 8'd5};
    push_seq(1, 9);
    drive_matrix(3, 3, 9);
    check("3x3_latency_valid", 32'(data_out_valid), 32'd1);
    check("3x3_drain_in_rdy", 32'(data_in_rdy), 32'd0);
    check("3x3_first_out", 32'(data_out), 32'd1);
    wait_drain();

    // 1x1
    in_q = '{8'hA5};
    push_exp(8'hA5, 1'b1);
    drive_matrix(1, 1, 1);
    check("1x1_state_drain", 32'(state_dbg), 32'd2);
    check("1x1_valid", 32'(data_out_valid), 32'd1);
    @(negedge clk);
    check("1x1_state_idle", 32'(state_dbg), 32'd0);
    check("1x1_in_rdy_back", 32'(data_in_rdy), 32'd1);
    check("1x1_valid_low", 32'(data_out_valid), 32'd0);

    // 1x5 and 5x1
    in_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
    push_seq(1, 5);
    drive_matrix(1, 5, 5);
    wait_drain();
    in_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
    push_seq(1, 5);
    drive_matrix(5, 1, 5);
    wait_drain();

    // 2x4 with toggling downstream ready
    rdy_toggle = 1'b1;
    in_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd8, 8'd7, 8'd6, 8'd5};
    push_seq(1, 8);
    drive_matrix(2, 4, 8);
    wait_drain();
    rdy_toggle = 1'b0;
    repeat (2) @(negedge clk);

    // 7x7 then a back-to-back 3x4 offered during the drain
    model_matrix(7, 7, 0);
    drive_matrix(7, 7, 49);
    model_matrix(3, 4, 100);
    drive_matrix(3, 4, 12);
    wait_drain();

    // reset mid-fill
    in_q = '{8'd1, 8'd2, 8'd3, 8'd6};
    drive_matrix(3, 3, 4);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", 32'(data_out_valid), 32'd0);
    check("midrst_in_rdy", 32'(data_in_rdy), 32'd0);
    check("midrst_state", 32'(state_dbg), 32'd0);
    rst = 1'b0;
    in_q = '{8'd1, 8'd2, 8'd4, 8'd3};
    push_seq(1, 4);
    drive_matrix(2, 2, 4);
    wait_drain();

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
